helen_nios_1_cpu_debug_arbiter: RTL

HELEN_NIOS_1_CPU_DEBUG_ARBITER -- requirements
Module: helen_nios_1_cpu_debug_arbiter

---
 rtl/helen_nios_1_cpu_debug_arbiter_if.sv | 38 +++
 rtl/helen_nios_1_cpu_debug_arbiter.sv | 108 ++++++++++
 2 files changed

// File: rtl/helen_nios_1_cpu_debug_arbiter_if.sv
// Requester / shared-port bundle for the debug arbiter; slave = arbiter view, master = environment view.
// Per-requester request, payload and ack on one side, the Avalon-style shared port on the other.
interface helen_nios_1_cpu_debug_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic [1:0]        req;
    logic [1:0]        req_wr;
    logic [ADDR_W-1:0] req_addr0;
    logic [ADDR_W-1:0] req_addr1;
    logic [DATA_W-1:0] req_wdata0;
    logic [DATA_W-1:0] req_wdata1;
    logic [1:0]        ack;
    logic              err;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        grant;
    logic [ADDR_W-1:0] m_address;
    logic              m_read;
    logic              m_write;
    logic [DATA_W-1:0] m_writedata;
    logic [DATA_W-1:0] m_readdata;
    logic              m_waitrequest;
    logic [7:0]        timeout_count;

    modport slave (
        input  req, req_wr, req_addr0, req_addr1, req_wdata0, req_wdata1,
        input  m_readdata, m_waitrequest,
        output ack, err, rdata, grant, m_address, m_read, m_write, m_writedata,
        output timeout_count
    );

    modport master (
        output req, req_wr, req_addr0, req_addr1, req_wdata0, req_wdata1,
        output m_readdata, m_waitrequest,
        input  ack, err, rdata, grant, m_address, m_read, m_write, m_writedata,
        input  timeout_count
    );
endinterface

// File: rtl/helen_nios_1_cpu_debug_arbiter.sv
// Two-requester (JTAG / host CSR) arbiter onto one shared port; req->cmd 1 cycle, zero-wait ack 2 cycles.
// Holds the command while m_waitrequest is high, aborting with err after TIMEOUT wait cycles.
module helen_nios_1_cpu_debug_arbiter #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    helen_nios_1_cpu_debug_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t            state_q;
    logic              last_q;
    logic [7:0]        wait_q;
    logic [7:0]        tocnt_q;
    logic [1:0]        grant_q;
    logic [1:0]        ack_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;
    logic              m_read_q;
    logic              m_write_q;
    logic [ADDR_W-1:0] m_address_q;
    logic [DATA_W-1:0] m_writedata_q;
    logic              win_d;

    // Tie goes to whoever was not granted last; a lone requester wins outright.
    always_comb begin
        win_d = 1'b0;
        if (bus.req == 2'b10) begin
            win_d = 1'b1;
        end else if (bus.req == 2'b11) begin
            win_d = ~last_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            last_q        <= 1'b1;
            wait_q        <= '0;
            tocnt_q       <= '0;
            grant_q       <= '0;
            ack_q         <= '0;
            err_q         <= 1'b0;
            rdata_q       <= '0;
            m_read_q      <= 1'b0;
            m_write_q     <= 1'b0;
            m_address_q   <= '0;
            m_writedata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    ack_q <= '0;
                    if (|bus.req) begin
                        state_q       <= BUS;
                        last_q        <= win_d;
                        grant_q       <= win_d ? 2'b10 : 2'b01;
                        m_read_q      <= ~bus.req_wr[win_d];
                        m_write_q     <= bus.req_wr[win_d];
                        m_address_q   <= win_d ? bus.req_addr1 : bus.req_addr0;
                        m_writedata_q <= win_d ? bus.req_wdata1 : bus.req_wdata0;
                        wait_q        <= '0;
                    end
                end
                BUS: begin
                    if (!bus.m_waitrequest || wait_q == TO_LAST) begin
                        state_q   <= DONE;
                        ack_q     <= grant_q;
                        grant_q   <= '0;
                        m_read_q  <= 1'b0;
                        m_write_q <= 1'b0;
                        if (!bus.m_waitrequest) begin
                            err_q   <= 1'b0;
                            rdata_q <= m_write_q ? '0 : bus.m_readdata;
                        end else begin
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                            if (tocnt_q != 8'hFF) begin
                                tocnt_q <= tocnt_q + 8'd1;
                            end
                        end
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                DONE: begin
                    ack_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.grant         = grant_q;
    assign bus.ack           = ack_q;
    assign bus.err           = err_q;
    assign bus.rdata         = rdata_q;
    assign bus.m_read        = m_read_q;
    assign bus.m_write       = m_write_q;
    assign bus.m_address     = m_address_q;
    assign bus.m_writedata   = m_writedata_q;
    assign bus.timeout_count = tocnt_q;
endmodule
